// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam logic [InstrWidth-1:0] NopWordDefault = 32'h0000_0000;

  typedef enum logic [1:0] {
    StPrime,
    StRun,
    StStall
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_buf.sv
// One-entry pending-redirect register: newest set wins, consumed when nPC next advances.
module fetch_redirect_buf
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_i,
  input  logic [InstrWidth-1:0] target_i,
  input  logic                  consume_i,
  output logic                  valid_o,
  output logic [InstrWidth-1:0] target_o
);

  logic                  valid_d, valid_q;
  logic [InstrWidth-1:0] target_d, target_q;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (set_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end else if (consume_i) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC/nPC pair with one delay slot, IF/ID register, queued redirects.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 9,
  parameter logic [31:0] NOP_WORD = NopWordDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_le,
  input  logic               npc_le,
  input  logic               if_id_le,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc,
  output logic [31:0]        npc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic               if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
`endif
  output logic               misalign_err
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q, npc_d, npc_q;
  logic [31:0]  if_id_instr_d, if_id_instr_q, if_id_pc_d, if_id_pc_q;
  logic         if_id_valid_d, if_id_valid_q;
  logic         misalign_d, misalign_q;
  logic         prime, pc_adv, npc_adv, pend_valid;
  logic [31:0]  pend_target;

  assign prime   = (state_q == StPrime);
  assign pc_adv  = pc_le && !prime;
  assign npc_adv = npc_le && !prime;

  // A redirect that cannot update nPC this cycle is parked; any nPC advance consumes
  // or supersedes it.
  fetch_redirect_buf u_redirect_buf (
    .clk       (clk),
    .reset     (reset),
    .set_i     (branch_taken && !npc_adv),
    .target_i  (branch_target),
    .consume_i (npc_adv),
    .valid_o   (pend_valid),
    .target_o  (pend_target)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = misalign_q;

    unique case (state_q)
      StPrime: state_d = StRun;
      StRun:   if (!(pc_le && if_id_le)) state_d = StStall;
      StStall: if (pc_le && if_id_le) state_d = StRun;
      default: state_d = StPrime;
    endcase

    if (pc_adv) pc_d = npc_q;
    if (npc_adv) begin
      if (branch_taken)    npc_d = branch_target;
      else if (pend_valid) npc_d = pend_target;
      else                 npc_d = npc_q + 32'd4;
    end

    if (prime) begin
      if_id_instr_d = NOP_WORD;
      if_id_valid_d = 1'b0;
    end else if (if_id_le) begin
      if_id_pc_d = pc_q;
      if (pc_q[1:0] != 2'b00) begin
        if_id_instr_d = NOP_WORD;
        if_id_valid_d = 1'b0;
        misalign_d    = 1'b1;
      end else begin
        if_id_instr_d = imem_data;
        if_id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StPrime;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + 32'd4;
      if_id_instr_q <= NOP_WORD;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_d, fetch_count_q, stall_count_d, stall_count_q;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (!prime && if_id_le && (pc_q[1:0] == 2'b00)) fetch_count_d = fetch_count_q + 32'd1;
    if (state_q == StStall) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

  assign imem_addr    = pc_q[IMEM_AW-1:0];
  assign pc           = pc_q;
  assign npc          = npc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_valid  = if_id_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; word at byte address A in imem is 32'hC0DE_0000 + A/4.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, pc_le, npc_le, if_id_le, branch_taken;
  logic [31:0] branch_target;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, npc, if_id_instr, if_id_pc;
  logic        if_id_valid, misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  logic [31:0] imem [128];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr[8:2]];

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc_le         (pc_le),
    .npc_le        (npc_le),
    .if_id_le      (if_id_le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .npc           (npc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .misalign_err  (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_le(input logic v);
    pc_le    = v;
    npc_le   = v;
    if_id_le = v;
  endtask

  // Reset edge, release, then the PRIME edge; afterwards pc=0, npc=4.
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'hC0DE_0000 + i;
    reset = 1'b1;
    set_le(1'b1);
    branch_taken  = 1'b0;
    branch_target = '0;

    // 1: reset state, PRIME, sequential fetch
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_npc", npc, 32'h4);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_ifid_pc", if_id_pc, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    reset = 1'b0;
    step();
    check("prime_pc", pc, 32'h0);
    check("prime_npc", npc, 32'h4);
    check("prime_valid", {31'b0, if_id_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_ifid_pc", if_id_pc, 32'(4 * k));
      check("seq_instr", if_id_instr, 32'hC0DE_0000 + 32'(k));
      check("seq_valid", {31'b0, if_id_valid}, 32'h1);
      check("seq_pc", pc, 32'(4 * k + 4));
    end

    // 2: branch with delay slot
    do_reset();
    step();
    step();
    check("br_pre_pc", pc, 32'h8);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    check("br_slot_pc", pc, 32'hC);
    check("br_slot_npc", npc, 32'h40);
    step();
    check("br_tgt_pc", pc, 32'h40);
    step();
    check("br_next_pc", pc, 32'h44);
    check("br_ifid_pc", if_id_pc, 32'h40);
    check("br_ifid_instr", if_id_instr, 32'hC0DE_0010);

    // 3: redirect queued during stall
    set_le(1'b0);
    for (int c = 1; c <= 3; c++) begin
      branch_taken  = (c == 2);
      branch_target = 32'h80;
      step();
      check("stl_pc", pc, 32'h44);
      check("stl_npc", npc, 32'h48);
      check("stl_ifid_pc", if_id_pc, 32'h40);
      check("stl_instr", if_id_instr, 32'hC0DE_0010);
    end
    branch_taken = 1'b0;
    set_le(1'b1);
    step();
    check("rel_pc", pc, 32'h48);
    check("rel_npc", npc, 32'h80);
    check("rel_ifid_pc", if_id_pc, 32'h44);
    step();
    check("rel_tgt_pc", pc, 32'h80);

    // 4: reset mid-stall drops the pending redirect
    set_le(1'b0);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'hC0;
    step();
    branch_taken = 1'b0;
    reset = 1'b1;
    step();
    check("rs_pc", pc, 32'h0);
    check("rs_npc", npc, 32'h4);
    check("rs_valid", {31'b0, if_id_valid}, 32'h0);
    reset = 1'b0;
    set_le(1'b1);
    step();
    check("rs_prime_npc", npc, 32'h4);
    step();
    check("rs_npc1", npc, 32'h8);
    step();
    check("rs_pc2", pc, 32'h8);
    check("rs_npc2", npc, 32'hC);

    // 5: misaligned target
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    step();
    branch_taken = 1'b0;
    step();
    check("mis_pc", pc, 32'h42);
    check("mis_pre_err", {31'b0, misalign_err}, 32'h0);
    step();
    check("mis_instr", if_id_instr, 32'h0);
    check("mis_valid", {31'b0, if_id_valid}, 32'h0);
    check("mis_err", {31'b0, misalign_err}, 32'h1);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    step();
    check("mis_realign_pc", pc, 32'h100);
    step();
    check("mis_ok_valid", {31'b0, if_id_valid}, 32'h1);
    check("mis_ok_instr", if_id_instr, 32'hC0DE_0040);
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    do_reset();
    check("mis_cleared", {31'b0, misalign_err}, 32'h0);

    // 6: wrap at 2^32
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_npc", npc, 32'h0);
    check("wrap_addr", {23'b0, imem_addr}, 32'h1FC);
    step();
    check("wrap_pc0", pc, 32'h0);
    check("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_instr", if_id_instr, 32'hC0DE_007F);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    check("perf_rst_fetch", fetch_count, 32'h0);
    check("perf_rst_stall", stall_count, 32'h0);
    for (int k = 0; k < 4; k++) step();
    set_le(1'b0);
    step();
    step();
    set_le(1'b1);
    for (int k = 0; k < 6; k++) step();
    check("perf_fetch", fetch_count, 32'd10);
    check("perf_stall", stall_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the 5-stage MIPS pipeline; it owns the PC/nPC pair with delay-slot semantics and drives the 9-bit instruction-memory address. It captures the returned word into the IF/ID register and produces its outputs: instruction, PC and valid.
- Honours PC_LE, nPC_LE and IF_ID_LE from the hazard/forwarding unit.
- Accepts branch/jump redirects from the ID-stage condition handler.
- Queues a redirect that arrives during a stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4
IMEM_AW, 9, instruction-memory address width (byte address)
NOP_WORD, 32'h0000_0000, word injected into IF/ID on bubbles and misaligned fetches

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_le  in  1  PC load enable (0 = hold PC)
npc_le  in  1  nPC load enable (0 = hold nPC)
if_id_le  in  1  IF/ID register load enable (0 = hold IF/ID contents)
branch_taken  in  1  redirect request from ID (branch/jump resolved taken)
branch_target  in  32  redirect target address
imem_addr  out  IMEM_AW  combinational: pc[IMEM_AW-1:0]
imem_data  in  32  instruction word, combinational response to imem_addr
pc  out  32  current PC
npc  out  32  current nPC
if_id_instr  out  32  IF/ID instruction
if_id_pc  out  32  PC of the instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real fetched instruction
misalign_err  out  1  sticky: a fetch with pc[1:0]!=0 occurred

Behaviour:
- One clock and one reset: clk, with reset synchronous and active-high. reset is sampled only on the rising edge of clk.
- Reset (any state, including mid-stall or with a redirect pending):
  - pc=RESET_PC, npc=RESET_PC+4.
  - if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0.
  - misalign_err=0, pending redirect cleared, FSM enters PRIME.
- FSM states:
  - PRIME: exactly one cycle after reset deasserts. PC/nPC hold; IF/ID loads NOP_WORD with valid=0. Then go to RUN.
  - RUN: normal fetch.
  - STALL: entered from RUN when pc_le=0 or if_id_le=0; returns to RUN in the first cycle both are 1.
- PC update, when pc_le=1 and not PRIME: pc<=npc.
- nPC update, when npc_le=1 and not PRIME, in priority order:
  - live branch_taken: npc<=branch_target;
  - else pending redirect valid: npc<=pending target, pending cleared;
  - else npc<=npc+4.
- This implements one architectural delay slot: the instruction after a branch always executes.
- Redirect while npc_le=0: branch_target captured into a 1-entry pending register, applied on the next npc_le=1 cycle.
  - A second branch_taken while pending is valid overwrites it; the newest wins.
- All PC/nPC arithmetic is modulo 2^32. imem_addr wraps at 2^IMEM_AW. Wrap is not an error.
- IF/ID, when if_id_le=1 and state RUN/STALL-exit:
  - if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1.
  - If pc[1:0]!=0: load NOP_WORD with valid=0 instead, and set misalign_err (stays set until reset).
  - When if_id_le=0: all IF/ID outputs hold.
- Latency: the instruction at address A appears on if_id_instr one edge after pc==A with if_id_le=1.
- Simultaneous pc_le=1, npc_le=0: pc<=npc while nPC holds, so the same address is fetched twice. This is legal and the hazard unit guarantees consistency.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both cleared by reset and wrapping at 2^32.
  - fetch_count increments on each IF/ID load with valid=1.
  - stall_count increments on each cycle spent in STALL.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: FSM state typedef (PRIME, RUN, STALL), NOP_WORD default, instruction width constant (32).
- One natural sub-module, fetch_redirect_buf: the 1-entry pending-redirect register with set/overwrite/consume logic.
- PC/nPC and IF/ID stay inline.

Test Plan:
1. Reset then run with all LE=1 and imem[0..12] = I0..I3. Required: cycle after PRIME has pc=0/npc=4; then if_id_pc sequences 0,4,8,12 with matching words and valid=1.
2. branch_taken=1, target=0x40, pulsed while pc=8. Required: next pcs are 12 (delay slot), then 0x40, then 0x44.
3. Redirect during stall: pc_le=npc_le=if_id_le=0 for 3 cycles with branch_taken pulsed (target 0x80) in stall cycle 2. Required: pc/npc/IF/ID hold throughout; after release npc becomes 0x80 and the next-but-one pc is 0x80.
4. reset=1 asserted mid-stall with a pending redirect. Required: pc=RESET_PC, valid=0, pending dropped; the pending target never appears on pc.
5. branch_target=0x42, taken. Required: the fetch at 0x42 loads NOP_WORD with valid=0; misalign_err=1 and stays 1 until reset.
6. With FETCH_PERF_CNT_EN, run 10 fetches containing 2 stall cycles. Required: fetch_count=10, stall_count=2. Separately, pc=0xFFFF_FFFC with LE=1 gives npc wrapping to 0x0000_0000.
